// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared definitions for the edge_generator block.
//   - FSM state encoding (IDLE / HOLD)
//   - request-decode constants (REQ_NONE / REQ_SET / REQ_CLR / REQ_TOG)
//   - decode_req():    folds the three request pulses into one request code
//   - target_level():  level a request asks for, given pending slot and signal
package edge_gen_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_SET  = 2'd1;
  localparam logic [1:0] REQ_CLR  = 2'd2;
  localparam logic [1:0] REQ_TOG  = 2'd3;

  // rise+fall in the same cycle is treated as a toggle.
  function automatic logic [1:0] decode_req(input logic rise, input logic fall,
                                            input logic tog);
    logic [1:0] r;
    if (tog || (rise && fall)) r = REQ_TOG;
    else if (rise)             r = REQ_SET;
    else if (fall)             r = REQ_CLR;
    else                       r = REQ_NONE;
    return r;
  endfunction

  // Toggle inverts the effective level: the queued target if one exists,
  // otherwise the current output.
  function automatic logic target_level(input logic [1:0] req,
                                        input logic pend_vld,
                                        input logic pend_tgt,
                                        input logic sig);
    logic t;
    case (req)
      REQ_SET: t = 1'b1;
      REQ_CLR: t = 1'b0;
      REQ_TOG: t = ~(pend_vld ? pend_tgt : sig);
      default: t = sig;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/edge_generator_if.sv
// edge_generator_if: request pulses in, generated level and status out.
//   rise_req / fall_req / toggle_req : single-cycle request pulses
//   signal      : generated level
//   busy        : dwell in progress
//   edge_strobe : first cycle of a new level
//   req_drop    : a request was discarded (queue full)
// master = request source, slave = edge_generator.
interface edge_generator_if;
  logic rise_req;
  logic fall_req;
  logic toggle_req;
  logic signal;
  logic busy;
  logic edge_strobe;
  logic req_drop;

  modport master (
    output rise_req, fall_req, toggle_req,
    input  signal, busy, edge_strobe, req_drop
  );

  modport slave (
    input  rise_req, fall_req, toggle_req,
    output signal, busy, edge_strobe, req_drop
  );
endinterface

// File: rtl/edge_generator_hold_counter.sv
// hold_counter: loadable down-counter that times the dwell of each level.
//   clk, reset  : clock, synchronous active-high reset (counter -> 0)
//   load_i      : load load_val_i this cycle (wins over decrement)
//   load_val_i  : value to load
//   zero_o      : counter is zero (final dwell cycle)
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)               cnt_d = load_val_i;
    else if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_generator.sv
// edge_generator: turns rise/fall/toggle request pulses into a level on
// `signal`, enforcing minimum high/low dwell times and queuing one request
// issued during a dwell.
//   clk, reset : clock, synchronous active-high reset
//   bus        : edge_generator_if.slave (requests in, level/status out)
// All outputs come straight from registers.
module edge_generator
  import edge_gen_pkg::*;
#(
  parameter int MIN_HIGH = 3,
  parameter int MIN_LOW  = 2,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  edge_generator_if.slave    bus
);

  localparam logic [CNT_W-1:0] LD_HIGH = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_LOW  = CNT_W'(MIN_LOW - 1);

  logic [0:0]       state_q, state_d;
  logic             sig_q, sig_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_tgt_q, pend_tgt_d;
  logic             strobe_q, strobe_d;
  logic             drop_q, drop_d;

  logic [1:0]       req;
  logic             has_req;
  logic             tgt;
  logic             flip_en;
  logic             flip_val;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign req     = decode_req(bus.rise_req, bus.fall_req, bus.toggle_req);
  assign has_req = (req != REQ_NONE);
  // In IDLE the pending slot is always empty, so one target serves all states.
  assign tgt     = target_level(req, pend_vld_q, pend_tgt_q, sig_q);

  always_comb begin
    state_d    = state_q;
    sig_d      = sig_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    strobe_d   = 1'b0;
    drop_d     = 1'b0;
    flip_en    = 1'b0;
    flip_val   = sig_q;

    if (state_q == IDLE) begin
      if (has_req && (tgt != sig_q)) begin
        flip_en  = 1'b1;
        flip_val = tgt;
      end
    end else if (!cnt_zero) begin
      // Mid-dwell: queue one request, drop anything beyond that.
      if (has_req) begin
        if (!pend_vld_q) begin
          pend_vld_d = 1'b1;
          pend_tgt_d = tgt;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else begin
      // Final dwell cycle.
      if (pend_vld_q && (pend_tgt_q != sig_q)) begin
        // Apply the queued level; a request arriving now takes its place,
        // with its toggle already resolved against the queued level.
        flip_en    = 1'b1;
        flip_val   = pend_tgt_q;
        pend_vld_d = has_req;
        pend_tgt_d = tgt;
      end else begin
        // A queued no-op is dropped silently; a fresh request is served
        // immediately, exactly as from IDLE.
        pend_vld_d = 1'b0;
        if (has_req && (tgt != sig_q)) begin
          flip_en  = 1'b1;
          flip_val = tgt;
        end else begin
          state_d = IDLE;
        end
      end
    end

    if (flip_en) begin
      sig_d    = flip_val;
      strobe_d = 1'b1;
      state_d  = HOLD;
    end
  end

  assign cnt_load     = flip_en;
  assign cnt_load_val = flip_val ? LD_HIGH : LD_LOW;

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sig_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 1'b0;
      strobe_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      strobe_q   <= strobe_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.signal      = sig_q;
  assign bus.busy        = (state_q == HOLD);
  assign bus.edge_strobe = strobe_q;
  assign bus.req_drop    = drop_q;

endmodule

// File: tb/tb_edge_generator.sv
// Bench for edge_generator: two instances (MIN 3/2 and MIN 1/1) driven with
// the same directed then random request stream, compared every cycle against
// a timeline model (time since last edge + a one-deep request queue).
module tb_edge_generator;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  edge_generator_if if_a ();
  edge_generator_if if_b ();

  edge_generator #(.MIN_HIGH(3), .MIN_LOW(2), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst), .bus(if_a)
  );
  edge_generator #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit sig;
    int since;   // cycles since the level last changed (0 = strobe cycle)
    bit q_has;
    bit q_val;
    bit strobe;
    bit drop;
  } mstate_t;

  localparam int FAR = 1000;

  mstate_t ma, mb;

  function automatic mstate_t mflip(mstate_t s, bit v);
    mstate_t n = s;
    n.sig = v; n.since = 0; n.strobe = 1'b1;
    return n;
  endfunction

  function automatic mstate_t mstep(mstate_t s, bit r, bit f, bit t, bit rs,
                                    int mh, int ml);
    mstate_t n = s;
    int dur;
    bit busy, last, want, eff, tgt;
    n.strobe = 1'b0; n.drop = 1'b0;
    if (rs) begin
      n.sig = 1'b0; n.since = FAR; n.q_has = 1'b0; n.q_val = 1'b0;
      return n;
    end
    dur  = s.sig ? mh : ml;
    busy = s.since < dur;
    last = busy && (s.since == dur - 1);
    want = r | f | t;
    eff  = s.q_has ? s.q_val : s.sig;
    tgt  = (t || (r && f)) ? !eff : r;
    if (n.since < FAR) n.since = n.since + 1;
    if (!busy) begin
      if (want && tgt != s.sig) n = mflip(n, tgt);
    end else if (!last) begin
      if (want) begin
        if (!s.q_has) begin n.q_has = 1'b1; n.q_val = tgt; end
        else n.drop = 1'b1;
      end
    end else begin
      if (s.q_has && s.q_val != s.sig) begin
        n = mflip(n, s.q_val);
        n.q_has = want; n.q_val = tgt;
      end else begin
        n.q_has = 1'b0;
        if (want && tgt != s.sig) n = mflip(n, tgt);
      end
    end
    return n;
  endfunction

  function automatic bit mbusy(mstate_t s, int mh, int ml);
    return s.since < (s.sig ? mh : ml);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge sample them, then check both DUTs.
  task automatic cyc(input bit r, input bit f, input bit t, input bit rs);
    rst = rs;
    if_a.rise_req = r; if_a.fall_req = f; if_a.toggle_req = t;
    if_b.rise_req = r; if_b.fall_req = f; if_b.toggle_req = t;
    @(posedge clk);
    ma = mstep(ma, r, f, t, rs, 3, 2);
    mb = mstep(mb, r, f, t, rs, 1, 1);
    #1;
    chk("a_signal", if_a.signal,      ma.sig);
    chk("a_busy",   if_a.busy,        mbusy(ma, 3, 2));
    chk("a_strobe", if_a.edge_strobe, ma.strobe);
    chk("a_drop",   if_a.req_drop,    ma.drop);
    chk("b_signal", if_b.signal,      mb.sig);
    chk("b_busy",   if_b.busy,        mbusy(mb, 1, 1));
    chk("b_strobe", if_b.edge_strobe, mb.strobe);
    chk("b_drop",   if_b.req_drop,    mb.drop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    ma = '{sig: 0, since: FAR, q_has: 0, q_val: 0, strobe: 0, drop: 0};
    mb = ma;
    rst = 1'b1;
    if_a.rise_req = 0; if_a.fall_req = 0; if_a.toggle_req = 0;
    if_b.rise_req = 0; if_b.fall_req = 0; if_b.toggle_req = 0;

    // Reset state, including a request presented during reset.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("rst_signal", if_a.signal, 1'b0);
    chk("rst_busy",   if_a.busy,   1'b0);
    idle(1);

    // 1: single rise, dwell of 3 high cycles then idle.
    cyc(1, 0, 0, 0);
    chk("s1_rise_sig", if_a.signal, 1'b1);
    chk("s1_strobe",   if_a.edge_strobe, 1'b1);
    idle(2);
    chk("s1_busy_end", if_a.busy, 1'b1);
    idle(1);
    chk("s1_idle",     if_a.busy, 1'b0);
    chk("s1_hold_sig", if_a.signal, 1'b1);
    idle(2);

    // 2: fall queued during high dwell, applied exactly at the dwell end.
    cyc(0, 1, 0, 0);            // back to 0 first
    idle(3);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    idle(1);
    chk("s2_still_hi", if_a.signal, 1'b1);
    idle(1);
    chk("s2_fell",     if_a.signal, 1'b0);
    chk("s2_strobe",   if_a.edge_strobe, 1'b1);
    idle(1);
    chk("s2_busy_lo",  if_a.busy, 1'b1);
    idle(1);
    chk("s2_idle",     if_a.busy, 1'b0);
    idle(2);

    // 3: third request while one is queued is dropped.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("s3_drop",  if_a.req_drop, 1'b1);
    idle(1);
    chk("s3_drop1", if_a.req_drop, 1'b0);
    idle(6);
    chk("s3_final", if_a.signal, 1'b0);

    // 4: rise+fall together from low acts as toggle.
    cyc(1, 1, 0, 0);
    chk("s4_sig",    if_a.signal, 1'b1);
    chk("s4_strobe", if_a.edge_strobe, 1'b1);
    idle(4);

    // 5: rise while already high and idle is a no-op.
    cyc(1, 0, 0, 0);
    chk("s5_strobe", if_a.edge_strobe, 1'b0);
    chk("s5_busy",   if_a.busy, 1'b0);
    chk("s5_drop",   if_a.req_drop, 1'b0);
    cyc(0, 1, 0, 0);
    idle(3);

    // 6: reset mid-dwell returns to low with no strobe, pending lost.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    chk("s6_sig",    if_a.signal, 1'b0);
    chk("s6_busy",   if_a.busy, 1'b0);
    chk("s6_strobe", if_a.edge_strobe, 1'b0);
    idle(5);
    chk("s6_quiet",  if_a.signal, 1'b0);

    // Toggle chains: back-to-back toggles on the MIN=1 instance edge every cycle.
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    idle(4);

    // Random stream.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
